// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, bit-period helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  // Full is the extra count bit; a pop frees the slot for a same-cycle push.
  assign o_full  = r_count[AW];
  assign o_empty = (r_count == '0);
  assign w_rd    = i_rd_en && !o_empty;
  assign w_wr    = i_wr_en && (!o_full || w_rd);
  assign o_count = r_count;
  // Head is forced to zero when empty so the output never shows stale data.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; no reset needed since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally on a power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a valid/ready byte stream through a FWFT FIFO.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB);
  // Timer counts down to zero, so load one less than the wanted interval.
  localparam logic [TW-1:0] LD_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] LD_BIT  = TW'(CPB - 1);

  logic [1:0]        r_sync;
  rx_state_t         r_state;
  logic [TW-1:0]     r_tmr;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_shreg;
  logic              r_brk;
  logic              w_rxs;
  logic              w_expire;
  logic              w_push;
  logic              w_ferr;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_ovf;

  assign w_rxs    = r_sync[1];
  assign w_expire = (r_tmr == '0);
  assign w_push   = (r_state == STOP) && !r_brk && w_expire && w_rxs;
  assign w_ferr   = (r_state == STOP) && !r_brk && w_expire && !w_rxs;
  assign m_valid  = !w_empty;
  assign w_pop    = m_valid && m_ready;
  assign w_ovf    = w_push && w_full && !w_pop;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rxd};
  end

  // Receive FSM with bit timer and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_brk   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_state <= START;
            r_tmr   <= LD_HALF;
          end
        end
        START: begin
          if (w_expire) begin
            r_tmr <= LD_BIT;
            if (!w_rxs) begin
              r_state <= DATA;
              r_idx   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        DATA: begin
          if (w_expire) begin
            r_shreg <= {w_rxs, r_shreg[DATA_W-1:1]};
            r_tmr   <= LD_BIT;
            if (r_idx == 3'd7) r_state <= STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        STOP: begin
          // After a low stop bit, hold here until the line returns high.
          if (r_brk) begin
            if (w_rxs) begin
              r_brk   <= 1'b0;
              r_state <= IDLE;
              r_tmr   <= LD_BIT;
            end
          end else if (w_expire) begin
            r_tmr <= LD_BIT;
            if (w_rxs) r_state <= IDLE;
            else       r_brk   <= 1'b1;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (w_ferr)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (w_ovf)        overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_data (r_shreg),
    .i_rd_en   (w_pop),
    .o_rd_data (m_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count)
  );

endmodule
